reservation_station_n: RTL
==========================

Name: reservation_station_n

Overview:
Parametrised successor of the fixed 3-entry reservation station. Holds DEPTH issued operations and snoops the CDB to capture pending operands. Dispatches the oldest ready entry to its functional unit. Each entry keeps its label reserved until that label's result is broadcast on the CDB, so the register-file labels stay valid until then. Sits between the CU/RegFile issue path and one functional-unit state machine (pmf/mf/df).

Parameters:
DEPTH, 3, number of entries (1..15)
DATA_W, 32, operand/result width
LABEL_W, 4, tag width; label 0 = "no dependency"
OP_W, 2, opcode width
BASE_LABEL, 1, label of entry 0; entry i owns BASE_LABEL+i (all nonzero, must fit LABEL_W)

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
WEN  in  1  issue request
opCode  in  OP_W  issued operation
dataIn1  in  DATA_W  Vj
label1  in  LABEL_W  Qj
dataIn2  in  DATA_W  Vk
label2  in  LABEL_W  Qk
isFull  out  1  all entries busy (combinational)
writeable_labelOut  out  LABEL_W  label the next issue will receive; 0 when full (combinational)
BCEN  in  1  CDB valid
BClabel  in  LABEL_W  CDB tag
BCdata  in  DATA_W  CDB value
EXEable  in  1  functional unit can accept an operation this cycle
OutEn  out  1  dispatch pulse (registered)
opOut  out  OP_W  dispatched opcode (registered)
dataOut1  out  DATA_W  dispatched Vj (registered)
dataOut2  out  DATA_W  dispatched Vk (registered)
ready_labelOut  out  LABEL_W  dispatched entry label (registered)

Behaviour:
- Per-entry state: busy, dispatched, op, Vj, Qj, Vk, Qk. A DEPTH×DEPTH age matrix orders the entries by issue.
- Reset (nRST low, asynchronous) clears the whole block immediately.
  - All busy/dispatched bits and the age matrix clear to 0.
  - OutEn, opOut, dataOut1, dataOut2 and ready_labelOut go to 0.
  - isFull goes to 0 and writeable_labelOut goes to BASE_LABEL.
- Allocation: the target is the lowest-index non-busy entry.
  - writeable_labelOut = BASE_LABEL + that index, or 0 when isFull.
- Issue: on a posedge with WEN=1 and isFull=0, the target entry loads op, V and Q, and sets busy=1, dispatched=0.
  - The age matrix marks the new entry younger than all busy entries.
  - WEN while isFull is ignored; no state changes.
- Issue-time forwarding: if labelX≠0, BCEN=1 and BClabel==labelX on the same edge, the entry stores VX=BCdata and QX=0.
- Snoop: on every edge, each busy entry with Qj≠0 and Qj==BClabel (with BCEN=1) captures Vj=BCdata and sets Qj=0. Vk/Qk follow the same rule independently. Both operands may capture on the same edge.
- Ready: an entry is ready when busy, not dispatched, Qj=0 and Qk=0.
  - Readiness is evaluated from registered state only.
  - An operand captured at edge k makes the entry eligible at edge k+1.
- Dispatch: on a posedge with EXEable=1 and at least one ready entry, the oldest ready entry is selected.
  - Its op, Vj, Vk and label are registered to the outputs, and OutEn=1 for exactly that cycle.
  - The entry's dispatched bit is set.
  - Otherwise OutEn=0 and the data outputs hold their previous values.
- Release: on a posedge with BCEN=1 and BClabel equal to an entry's own label, that entry's busy bit clears.
  - Its age row/column clears.
  - A freed entry is reallocatable from the next cycle; writeable_labelOut uses pre-edge busy state.
- Minimum latency: an issue with both operands ready at edge k dispatches at edge k+1, with OutEn high during cycle k+1.
- Simultaneous events on one edge:
  - Issue, snoop, dispatch and release to different entries all take effect.
  - Release of entry X and a snoop of X's label by other entries both occur.
- Release of a not-yet-dispatched entry (protocol violation) still frees it; no dispatch follows.

Decomposition:
- Shared package tomasulo_pkg holds:
  - LABEL_NONE=0;
  - default DATA_W, LABEL_W, OP_W;
  - the opcode encodings shared with the CU.
- One sub-module, rs_entry, holds one entry's registers, snoop comparators, ready flag and release match, instantiated DEPTH times via generate.
- Allocation, the age matrix and dispatch select stay in the parent.

Test Plan:
1. Reset then issue op=1, label1=label2=0, Vj=5, Vk=7 with EXEable=1 -> writeable_labelOut was 1; next cycle OutEn=1, opOut=1, dataOut1=5, dataOut2=7, ready_labelOut=1.
2. Issue with label1=3 pending; later BCEN=1, BClabel=3, BCdata=0x11 -> Vj captured; OutEn=1 one cycle later with dataOut1=0x11.
3. Issue with label2=2 while BCEN=1, BClabel=2, BCdata=9 on the same edge -> dispatch next cycle with dataOut2=9 (forwarding).
4. Fill DEPTH=3 entries -> isFull=1, writeable_labelOut=0, extra WEN ignored. Broadcast label 2 -> next cycle isFull=0, writeable_labelOut=2.
5. Entries 3 then 1 issued blocked; both wake on one broadcast; EXEable=1 -> entry 3 (older) dispatched first, then entry 1 on the following edge.
6. Assert nRST low mid-dispatch, asynchronously between edges -> OutEn and all outputs 0 immediately; after release, writeable_labelOut=BASE_LABEL.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo issue/execute slice: the "no dependency"
// label value, default bus widths and the opcode encodings agreed with the CU.
// No ports (package).
// -----------------------------------------------------------------------------
package tomasulo_pkg;

  // Label value meaning "operand already present, nothing to wait for".
  localparam int LABEL_NONE      = 0;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_LABEL_W = 4;
  localparam int DEFAULT_OP_W    = 2;

  // Opcode encodings shared with the CU. The station itself treats the opcode
  // as opaque payload; the functional unit interprets it.
  typedef enum logic [DEFAULT_OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opCode_e;

endpackage

// File: rtl/rs_entry.sv
// -----------------------------------------------------------------------------
// rs_entry
// One reservation-station slot: holds busy/dispatched flags, opcode and the two
// operand value/tag pairs, snoops the CDB for pending tags, and flags when the
// CDB is broadcasting this slot's own label (which frees the slot).
//
// Ports:
//   clk, nRST                 clock, asynchronous active-low reset
//   alloc                     load this slot from the issue bus this edge
//   opIn, dataIn1/2, label1/2 issue bus (opcode, Vj/Qj, Vk/Qk)
//   bcEn, bcLabel, bcData     common data bus
//   dispatchSel               this slot is being dispatched this edge
//   busy                      slot holds an operation
//   ready                     busy, not yet dispatched, both operands present
//   releaseHit                CDB is broadcasting this slot's label (busy only)
//   op, vj, vk                stored opcode and operand values
// -----------------------------------------------------------------------------
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter int                 DATA_W   = DEFAULT_DATA_W,
  parameter int                 LABEL_W  = DEFAULT_LABEL_W,
  parameter int                 OP_W     = DEFAULT_OP_W,
  parameter logic [LABEL_W-1:0] MY_LABEL = 1
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               alloc,
  input  logic [OP_W-1:0]    opIn,
  input  logic [DATA_W-1:0]  dataIn1,
  input  logic [LABEL_W-1:0] label1,
  input  logic [DATA_W-1:0]  dataIn2,
  input  logic [LABEL_W-1:0] label2,
  input  logic               bcEn,
  input  logic [LABEL_W-1:0] bcLabel,
  input  logic [DATA_W-1:0]  bcData,
  input  logic               dispatchSel,
  output logic               busy,
  output logic               ready,
  output logic               releaseHit,
  output logic [OP_W-1:0]    op,
  output logic [DATA_W-1:0]  vj,
  output logic [DATA_W-1:0]  vk
);

  localparam logic [LABEL_W-1:0] NONE = LABEL_W'(LABEL_NONE);

  logic               busyReg;
  logic               dispatchedReg;
  logic [OP_W-1:0]    opReg;
  logic [DATA_W-1:0]  vjReg;
  logic [LABEL_W-1:0] qjReg;
  logic [DATA_W-1:0]  vkReg;
  logic [LABEL_W-1:0] qkReg;

  logic snoopJ;
  logic snoopK;
  logic fwdJ;
  logic fwdK;

  // Snoop on stored tags (only meaningful while busy).
  assign snoopJ = busyReg && bcEn && (qjReg != NONE) && (qjReg == bcLabel);
  assign snoopK = busyReg && bcEn && (qkReg != NONE) && (qkReg == bcLabel);

  // Forwarding of a value broadcast on the very edge the operation issues;
  // without it the tag would be stored after its only broadcast and never wake.
  assign fwdJ = bcEn && (label1 != NONE) && (label1 == bcLabel);
  assign fwdK = bcEn && (label2 != NONE) && (label2 == bcLabel);

  // Gated with busy so a slot being allocated on the same edge as a broadcast
  // of its own label is not freed by a result that belongs to its previous use.
  assign releaseHit = busyReg && bcEn && (bcLabel == MY_LABEL);

  assign busy  = busyReg;
  assign ready = busyReg && !dispatchedReg && (qjReg == NONE) && (qkReg == NONE);
  assign op    = opReg;
  assign vj    = vjReg;
  assign vk    = vkReg;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busyReg       <= 1'b0;
      dispatchedReg <= 1'b0;
      opReg         <= '0;
      vjReg         <= '0;
      qjReg         <= NONE;
      vkReg         <= '0;
      qkReg         <= NONE;
    end else if (alloc) begin
      busyReg       <= 1'b1;
      dispatchedReg <= 1'b0;
      opReg         <= opIn;
      vjReg         <= fwdJ ? bcData : dataIn1;
      qjReg         <= fwdJ ? NONE   : label1;
      vkReg         <= fwdK ? bcData : dataIn2;
      qkReg         <= fwdK ? NONE   : label2;
    end else begin
      if (releaseHit) begin
        busyReg <= 1'b0;
      end
      if (dispatchSel) begin
        dispatchedReg <= 1'b1;
      end
      if (snoopJ) begin
        vjReg <= bcData;
        qjReg <= NONE;
      end
      if (snoopK) begin
        vkReg <= bcData;
        qkReg <= NONE;
      end
    end
  end

endmodule

// File: rtl/reservation_station_n.sv
// -----------------------------------------------------------------------------
// reservation_station_n
// DEPTH-entry reservation station between the CU/RegFile issue path and one
// functional unit. Entries capture pending operands from the CDB and the oldest
// ready entry is dispatched whenever the unit can accept work. An entry keeps
// its label reserved until that label's result appears on the CDB.
//
// Ports:
//   clk, nRST                    clock, asynchronous active-low reset
//   WEN, opCode                  issue request and opcode
//   dataIn1/label1               Vj / Qj of the issued operation
//   dataIn2/label2               Vk / Qk of the issued operation
//   isFull                       all entries busy (combinational)
//   writeable_labelOut           label the next issue receives, 0 when full
//   BCEN, BClabel, BCdata        common data bus
//   EXEable                      functional unit can accept an operation
//   OutEn                        one-cycle dispatch pulse (registered)
//   opOut, dataOut1, dataOut2    dispatched opcode / Vj / Vk (registered)
//   ready_labelOut               label of the dispatched entry (registered)
// -----------------------------------------------------------------------------
module reservation_station_n
  import tomasulo_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int LABEL_W    = DEFAULT_LABEL_W,
  parameter int OP_W       = DEFAULT_OP_W,
  parameter int BASE_LABEL = 1
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               WEN,
  input  logic [OP_W-1:0]    opCode,
  input  logic [DATA_W-1:0]  dataIn1,
  input  logic [LABEL_W-1:0] label1,
  input  logic [DATA_W-1:0]  dataIn2,
  input  logic [LABEL_W-1:0] label2,
  output logic               isFull,
  output logic [LABEL_W-1:0] writeable_labelOut,
  input  logic               BCEN,
  input  logic [LABEL_W-1:0] BClabel,
  input  logic [DATA_W-1:0]  BCdata,
  input  logic               EXEable,
  output logic               OutEn,
  output logic [OP_W-1:0]    opOut,
  output logic [DATA_W-1:0]  dataOut1,
  output logic [DATA_W-1:0]  dataOut2,
  output logic [LABEL_W-1:0] ready_labelOut
);

  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   ready;
  logic [DEPTH-1:0]   releaseHit;
  logic [DEPTH-1:0]   allocSel;
  logic [DEPTH-1:0]   grant;
  logic [OP_W-1:0]    entryOp [DEPTH];
  logic [DATA_W-1:0]  entryVj [DEPTH];
  logic [DATA_W-1:0]  entryVk [DEPTH];

  // olderReg[i][j] = 1 when entry i was issued before entry j and both are
  // still busy. Rows/columns of free entries are kept at zero.
  logic [DEPTH-1:0]   olderReg  [DEPTH];
  logic [DEPTH-1:0]   olderNext [DEPTH];

  logic               issue;
  logic [LABEL_W-1:0] allocLabel;
  logic               dispatchValid;
  logic [OP_W-1:0]    selOp;
  logic [DATA_W-1:0]  selVj;
  logic [DATA_W-1:0]  selVk;
  logic [LABEL_W-1:0] selLabel;

  // ---------------------------------------------------------------------------
  // Entries
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gEntry
      rs_entry #(
        .DATA_W   (DATA_W),
        .LABEL_W  (LABEL_W),
        .OP_W     (OP_W),
        .MY_LABEL (LABEL_W'(BASE_LABEL + gi))
      ) uEntry (
        .clk         (clk),
        .nRST        (nRST),
        .alloc       (issue && allocSel[gi]),
        .opIn        (opCode),
        .dataIn1     (dataIn1),
        .label1      (label1),
        .dataIn2     (dataIn2),
        .label2      (label2),
        .bcEn        (BCEN),
        .bcLabel     (BClabel),
        .bcData      (BCdata),
        .dispatchSel (grant[gi]),
        .busy        (busy[gi]),
        .ready       (ready[gi]),
        .releaseHit  (releaseHit[gi]),
        .op          (entryOp[gi]),
        .vj          (entryVj[gi]),
        .vk          (entryVk[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Allocation: lowest-index free entry, from pre-edge busy state.
  // ---------------------------------------------------------------------------
  always_comb begin
    allocSel   = '0;
    allocLabel = '0;
    // Walk downwards so the lowest free index is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        allocSel    = '0;
        allocSel[i] = 1'b1;
        allocLabel  = LABEL_W'(BASE_LABEL + i);
      end
    end
  end

  assign isFull             = &busy;
  assign writeable_labelOut = isFull ? LABEL_W'(LABEL_NONE) : allocLabel;
  assign issue              = WEN && !isFull;

  // ---------------------------------------------------------------------------
  // Dispatch select: an entry wins if it is ready and no older entry is ready.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gSel
      logic [DEPTH-1:0] olderThanMe;
      always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
          olderThanMe[j] = olderReg[j][gi];
        end
      end
      assign grant[gi] = EXEable && ready[gi] && !(|(olderThanMe & ready));
    end
  endgenerate

  assign dispatchValid = |grant;

  always_comb begin
    selOp    = '0;
    selVj    = '0;
    selVk    = '0;
    selLabel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        selOp    = entryOp[i];
        selVj    = entryVj[i];
        selVk    = entryVk[i];
        selLabel = LABEL_W'(BASE_LABEL + i);
      end
    end
  end

  // Data outputs only move on a dispatch so the unit sees stable operands.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      OutEn          <= 1'b0;
      opOut          <= '0;
      dataOut1       <= '0;
      dataOut2       <= '0;
      ready_labelOut <= '0;
    end else begin
      OutEn <= dispatchValid;
      if (dispatchValid) begin
        opOut          <= selOp;
        dataOut1       <= selVj;
        dataOut2       <= selVk;
        ready_labelOut <= selLabel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Age matrix update
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      olderNext[i] = olderReg[i];
      // Released entries drop out of the ordering in both directions.
      if (releaseHit[i]) begin
        olderNext[i] = '0;
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (releaseHit[j]) begin
          olderNext[i][j] = 1'b0;
        end
      end
      // The new entry is younger than every entry that survives this edge.
      if (issue) begin
        if (allocSel[i]) begin
          olderNext[i] = '0;
        end else if (busy[i] && !releaseHit[i]) begin
          olderNext[i] = olderNext[i] | allocSel;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        olderReg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        olderReg[i] <= olderNext[i];
      end
    end
  end

endmodule
